// File: rtl/vector_serializer_pkg.sv
// Shared types for the vector serializer: Q16.16 scalar, 4-component vector,
// component index constants and the serializer state encoding.
package vector_serializer_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned NUM_COMP = 4;
  localparam int unsigned IDX_W    = 2;

  typedef logic signed [FP_W-1:0] FixedPoint_t;

  // x occupies the least significant slice
  typedef struct packed {
    FixedPoint_t w;
    FixedPoint_t z;
    FixedPoint_t y;
    FixedPoint_t x;
  } Vector4_t;

  localparam logic [IDX_W-1:0] VECTOR_X = IDX_W'(0);
  localparam logic [IDX_W-1:0] VECTOR_Y = IDX_W'(1);
  localparam logic [IDX_W-1:0] VECTOR_Z = IDX_W'(2);
  localparam logic [IDX_W-1:0] VECTOR_W = IDX_W'(3);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/vector_serializer_if.sv
// Vector-in / scalar-out handshake bundle; slave is the serializer's view.
interface vector_serializer_if;
  import vector_serializer_pkg::*;

  logic                i_valid;
  logic                o_ready;
  Vector4_t            i_vector;
  logic [NUM_COMP-1:0] i_mask;
  logic                o_valid;
  logic                i_ready;
  FixedPoint_t         o_data;
  logic [IDX_W-1:0]    o_index;
  logic                o_last;

  modport slave (
    input  i_valid, i_vector, i_mask, i_ready,
    output o_ready, o_valid, o_data, o_index, o_last
  );

  modport master (
    output i_valid, i_vector, i_mask, i_ready,
    input  o_ready, o_valid, o_data, o_index, o_last
  );

endinterface

// File: rtl/VectorSelect.sv
// Combinational component extractor: returns component i_index of i_vector.
module VectorSelect
  import vector_serializer_pkg::*;
(
  input  Vector4_t         i_vector,
  input  logic [IDX_W-1:0] i_index,
  output FixedPoint_t      o_result
);

  always_comb begin
    o_result = i_vector.x;
    case (i_index)
      VECTOR_X: o_result = i_vector.x;
      VECTOR_Y: o_result = i_vector.y;
      VECTOR_Z: o_result = i_vector.z;
      VECTOR_W: o_result = i_vector.w;
      default:  o_result = i_vector.x;
    endcase
  end

endmodule

// File: rtl/vector_serializer.sv
// Streams the masked components of an accepted Vector4_t, lowest index first,
// one scalar beat per cycle; a final-beat transfer can overlap the next accept.
module vector_serializer
  import vector_serializer_pkg::*;
(
  input logic                i_clk,
  input logic                i_reset_n,
  vector_serializer_if.slave bus
);

  state_e              state_q, state_d;
  logic [NUM_COMP-1:0] rem_q, rem_d;
  Vector4_t            vec_q, vec_d;

  logic [IDX_W-1:0]    idx_c;
  logic                last_c;
  logic                valid_c;
  logic                xfer_c;
  logic                ready_c;
  logic                accept_c;
  FixedPoint_t         data_c;

  // Lowest set bit of the remaining mask; scanning downward lets the lowest win
  always_comb begin
    idx_c = IDX_W'(0);
    for (int i = NUM_COMP - 1; i >= 0; i--) begin
      if (rem_q[i]) idx_c = IDX_W'(i);
    end
  end

  // Exactly one bit left means this beat closes the vector
  assign valid_c  = (state_q == ST_STREAM);
  assign last_c   = valid_c && ((rem_q & (rem_q - NUM_COMP'(1))) == '0);
  assign xfer_c   = valid_c && bus.i_ready;
  assign ready_c  = (state_q == ST_IDLE) || (xfer_c && last_c);
  assign accept_c = bus.i_valid && ready_c;

  // Next state: a same-cycle accept overrides the bit clear of the old vector
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    vec_d   = vec_q;
    if (xfer_c) begin
      rem_d = rem_q & ~(NUM_COMP'(1) << idx_c);
      if (last_c) state_d = ST_IDLE;
    end
    if (accept_c) begin
      vec_d   = bus.i_vector;
      rem_d   = bus.i_mask;
      state_d = (bus.i_mask != '0) ? ST_STREAM : ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      vec_q   <= vec_d;
    end
  end

  VectorSelect u_select (
    .i_vector (vec_q),
    .i_index  (idx_c),
    .o_result (data_c)
  );

  assign bus.o_valid = valid_c;
  assign bus.o_ready = ready_c;
  assign bus.o_data  = data_c;
  assign bus.o_index = idx_c;
  assign bus.o_last  = last_c;

endmodule

// File: tb/tb_vector_serializer.sv
// Self-checking bench for vector_serializer: directed scenarios plus random
// traffic, all checked against a queue of expected beats.
module tb_vector_serializer;
  import vector_serializer_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_serializer_if vif ();

  vector_serializer dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (vif)
  );

  typedef struct {
    FixedPoint_t data;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    beats   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic FixedPoint_t to_fx(input int n);
    return FixedPoint_t'(n * 65536);
  endfunction

  function automatic Vector4_t mk_vec(input int x, input int y, input int z, input int w);
    Vector4_t v;
    v.x = to_fx(x);
    v.y = to_fx(y);
    v.z = to_fx(z);
    v.w = to_fx(w);
    return v;
  endfunction

  // Reference: a vector becomes one beat per set mask bit, ascending, last on the final one
  task automatic push_vector(input Vector4_t v, input logic [3:0] m);
    FixedPoint_t comps[4];
    int          sel[$];
    beat_t       b;
    comps = '{v.x, v.y, v.z, v.w};
    for (int i = 0; i < 4; i++) if (m[i]) sel.push_back(i);
    for (int j = 0; j < sel.size(); j++) begin
      b.data = comps[sel[j]];
      b.idx  = 2'(sel[j]);
      b.last = (j == sel.size() - 1);
      exp_q.push_back(b);
    end
  endtask

  // One cycle: drive after negedge, compare settled outputs, update model, advance
  task automatic step(input logic v, input Vector4_t vec, input logic [3:0] m, input logic rdy);
    bit exp_valid;
    bit exp_ready;
    vif.i_valid  = v;
    vif.i_vector = vec;
    vif.i_mask   = m;
    vif.i_ready  = rdy;
    #1;
    exp_valid = (exp_q.size() != 0);
    exp_ready = !exp_valid || (rdy && exp_q.size() == 1);
    check("o_valid", 64'(vif.o_valid), 64'(exp_valid));
    check("o_ready", 64'(vif.o_ready), 64'(exp_ready));
    if (exp_valid) begin
      check("o_data",  64'(vif.o_data),  64'(exp_q[0].data));
      check("o_index", 64'(vif.o_index), 64'(exp_q[0].idx));
      check("o_last",  64'(vif.o_last),  64'(exp_q[0].last));
      if (rdy) begin
        void'(exp_q.pop_front());
        beats++;
      end
    end
    if (v && exp_ready) push_vector(vec, m);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 4'h0, 1'b1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_valid"}, 64'(vif.o_valid), 64'(0));
    check({tag, "_ready"}, 64'(vif.o_ready), 64'(1));
    check({tag, "_data"},  64'(vif.o_data),  64'(0));
    check({tag, "_index"}, 64'(vif.o_index), 64'(0));
    check({tag, "_last"},  64'(vif.o_last),  64'(0));
  endtask

  initial begin
    Vector4_t rv;
    int       b0;

    vif.i_valid  = 1'b0;
    vif.i_vector = '0;
    vif.i_mask   = 4'h0;
    vif.i_ready  = 1'b0;
    #2;
    check_reset_outs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Full mask, ready high
    step(1'b1, mk_vec(1, 2, 3, 4), 4'hF, 1'b1);
    idle(5);

    // Sparse mask 0101
    step(1'b1, mk_vec(5, 6, 7, 8), 4'h5, 1'b1);
    idle(3);

    // Zero mask is swallowed, then a w-only vector
    step(1'b1, mk_vec(1, 1, 1, 1), 4'h0, 1'b1);
    step(1'b0, '0, 4'h0, 1'b1);
    step(1'b1, mk_vec(0, 0, 0, 9), 4'h8, 1'b1);
    idle(2);

    // Backpressure while y is presented
    step(1'b1, mk_vec(11, 12, 13, 14), 4'hF, 1'b1);
    step(1'b0, '0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, mk_vec(99, 99, 99, 99), 4'hF, 1'b0);
    idle(4);

    // Back-to-back full vectors with i_valid held high
    b0 = beats;
    for (int c = 0; c < 13; c++) step(c < 12, mk_vec(20 + c, 40 + c, 60 + c, 80 + c), 4'hF, 1'b1);
    check("b2b_beats", 64'(beats - b0), 64'(12));
    check("b2b_drained", 64'(exp_q.size()), 64'(0));
    idle(2);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rv.x = FixedPoint_t'($urandom);
      rv.y = FixedPoint_t'($urandom);
      rv.z = FixedPoint_t'($urandom);
      rv.w = FixedPoint_t'($urandom);
      step(1'($urandom_range(0, 1)), rv, 4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7));
    end
    idle(6);
    check("rand_drained", 64'(exp_q.size()), 64'(0));

    // Reset asserted mid-stream after the second beat
    step(1'b1, mk_vec(31, 32, 33, 34), 4'hF, 1'b1);
    step(1'b0, '0, 4'h0, 1'b1);
    step(1'b0, '0, 4'h0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
